uart_prog_loader: RTL and testbench
===================================

Name: uart_prog_loader

Overview:
- Writer side of the UART programming interface. Takes the byte stream from the UART receiver and parses framed records.
- Produces the `upg_wen/upg_adr/upg_dat/upg_done` strobes that load instruction memory (`adr[14]=0`) and data memory (`adr[14]=1`).
- Runs in the UART programmer clock domain (10 MHz). Sits between the UART RX core and the CPU memories.

Parameters:
- `TIMEOUT_CYCLES`, 1000000, idle clocks allowed between bytes inside a record before abort.
- `MAX_WORDS`, 16384, largest legal word count per segment (14-bit word address space).

Ports:
- `clk` input 1: programmer clock (10 MHz).
- `reset` input 1: reset, asynchronous, active-high.
- `rx_data` input 8: received byte.
- `rx_valid` input 1: one-cycle strobe; `rx_data` valid this cycle.
- `upg_wen_o` output 1: one-cycle memory write strobe.
- `upg_adr_o` output 15: `{segment, word_index[13:0]}`.
- `upg_dat_o` output 32: assembled word.
- `upg_done_o` output 1: sticky; programming finished, CPU may run.
- `err_o` output 1: sticky; protocol error seen.
- `busy_o` output 1: high while inside a record.

Behaviour:
- Reset values: `upg_wen_o=0`, `upg_adr_o=0`, `upg_dat_o=0`, `upg_done_o=0`, `err_o=0`, `busy_o=0`, state IDLE, all counters 0.
- Record format:
  - CMD byte: 0x00 = instruction segment, 0x01 = data segment, 0xFF = end.
  - CNT_LO byte, then CNT_HI byte: word count N, little-endian.
  - N×4 payload bytes, each word little-endian (first byte → `dat[7:0]`).
- IDLE: on `rx_valid`:
  - 0x00/0x01 → latch segment bit, go to CNT_LO.
  - 0xFF → DONE.
  - Any other value → `err_o=1`, stay IDLE.
- CNT_LO: latch low byte → CNT_HI.
- CNT_HI: form N.
  - N=0 → IDLE, no writes.
  - N>`MAX_WORDS` → `err_o=1`, IDLE.
  - Otherwise clear `word_index` and byte counter, go to DATA.
- DATA: shift each byte into a 32-bit assembly register.
  - On the 4th byte of a word: next cycle `upg_wen_o=1` for exactly one cycle, with `upg_dat_o` = assembled word and `upg_adr_o={segment, word_index}`.
  - `adr/dat` hold their value after the strobe until the next write.
  - `word_index` increments after each write. When `word_index` reaches N → IDLE (or CSUM with the option).
- Throughput: at most one write per 4 `rx_valid`; the write latency of 1 cycle after the 4th byte is fixed.
- DONE: `upg_done_o=1` and held until reset. All further `rx_valid` are ignored; no writes.
- `busy_o=1` in CNT_LO, CNT_HI, DATA and CSUM.
- Timeout: a gap counter clears on every `rx_valid` and counts while `busy_o=1`.
  - Reaching `TIMEOUT_CYCLES` → `err_o=1`, partial word discarded, state IDLE.
  - A write strobe already issued is not retracted.
  - `rx_valid` in the same cycle as the terminal count: the byte wins and the counter clears.
- `err_o` never blocks parsing; the next valid CMD starts a fresh record.
- Reset mid-record: everything returns to reset values immediately. Any `upg_wen_o` pulse in flight is cancelled.
- A single segment's word index never wraps; overflow is prevented by the `MAX_WORDS` check.

Optional Feature:
- Macro: `UART_PROG_LOADER_CHECKSUM_EN`.
- Defined:
  - After the last payload byte, one checksum byte follows (CSUM state), equal to the XOR of all CNT and payload bytes of the record.
  - Mismatch → `err_o=1`. Either way return to IDLE.
  - The checksum byte is also subject to the timeout.
- Undefined: no CSUM state; DATA returns directly to IDLE.

Decomposition:
- Shared defines file holds:
  - Command codes `PROG_CMD_INST=8'h00`, `PROG_CMD_DATA=8'h01`, `PROG_CMD_END=8'hFF`.
  - State encodings.
  - Segment-select bit position 14.
- One natural sub-module, `prog_word_assembler`: byte-to-word shift register with byte counter and `word_ready` pulse.
- The FSM, counters and timeout stay in the top.

Test Plan:
- Inst segment, 2 words: bytes `00 02 00 78 56 34 12 EF BE AD DE` → wen pulses with (adr 0x0000, dat 0x12345678) then (adr 0x0001, dat 0xDEADBEEF); `busy_o` falls after the last byte.
- Data segment then end: `01 01 00 04 03 02 01 FF` → one write, adr 0x4000, dat 0x01020304; then `upg_done_o=1` and stays 1; extra bytes after FF cause no wen.
- Bad command 0x55 in IDLE → `err_o=1`, no writes. A following valid inst record still writes correctly.
- Timeout: `00 01 00 AA` then silence for `TIMEOUT_CYCLES` → `err_o=1`, no wen, state IDLE; a new record writes from adr 0.
- Reset asserted between the 3rd and 4th byte of a word → all outputs 0, no wen on the next byte. The parser treats the next byte as a CMD.
- With `UART_PROG_LOADER_CHECKSUM_EN`: record `00 01 00 01 02 03 04` + checksum 0x05 → write of 0x04030201, `err_o=0`; same record with checksum 0x06 → write issued, `err_o=1`.

Source files
------------

// File: rtl/uart_prog_loader_pkg.sv
// Shared command codes, parser state encoding and segment bit position for the
// UART programming loader.
package uart_prog_loader_pkg;

  localparam logic [7:0] PROG_CMD_INST = 8'h00;
  localparam logic [7:0] PROG_CMD_DATA = 8'h01;
  localparam logic [7:0] PROG_CMD_END  = 8'hFF;

  localparam int SEG_BIT = 14;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_LO = 3'd1,
    ST_CNT_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5
  } prog_state_t;

endpackage

// File: rtl/prog_word_assembler.sv
// Collects four little-endian bytes into a 32-bit word; o_word_ready pulses
// combinationally in the cycle the fourth byte is accepted.
module prog_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_byte_vld,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_ready
);

  logic [1:0]  r_byte_cnt;
  logic [23:0] r_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte_cnt <= '0;
    end else if (i_clear) begin
      r_byte_cnt <= '0;
    end else if (i_byte_vld) begin
      r_byte_cnt <= r_byte_cnt + 2'd1;
    end
  end

  // Shift right so the first byte ends up in the least significant lane.
  always_ff @(posedge clk) begin
    if (i_byte_vld) begin
      r_shift <= {i_byte, r_shift[23:8]};
    end
  end

  assign o_word       = {i_byte, r_shift};
  assign o_word_ready = i_byte_vld && !i_clear && (r_byte_cnt == 2'd3);

endmodule

// File: rtl/uart_prog_loader.sv
// Parses framed UART programming records into instruction/data memory writes.
// Optional trailing per-record checksum byte: define UART_PROG_LOADER_CHECKSUM_EN.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_WORDS      = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

  prog_state_t r_state, w_next_state;

  logic             r_seg;
  logic [7:0]       r_cnt_lo;
  logic [15:0]      r_count;
  logic [14:0]      r_word_idx;
  logic [GAP_W-1:0] r_gap;
  logic             r_wen;
  logic [14:0]      r_adr;
  logic [31:0]      r_dat;
  logic             r_err;

  logic [15:0] w_count;
  logic [14:0] w_idx_next;
  logic        w_busy;
  logic        w_timeout;
  logic        w_err_set;
  logic [31:0] w_word;
  logic        w_word_ready;

`ifdef UART_PROG_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
`endif

  prog_word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (r_state != ST_DATA),
    .i_byte_vld   (rx_valid && (r_state == ST_DATA)),
    .i_byte       (rx_data),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  assign w_count    = {rx_data, r_cnt_lo};
  assign w_idx_next = r_word_idx + 15'd1;
  assign w_busy     = (r_state == ST_CNT_LO) || (r_state == ST_CNT_HI) ||
                      (r_state == ST_DATA)   || (r_state == ST_CSUM);
  // A byte arriving on the terminal gap count takes priority over the abort.
  assign w_timeout  = w_busy && !rx_valid && (r_gap == GAP_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_err_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_data == PROG_CMD_INST || rx_data == PROG_CMD_DATA) w_next_state = ST_CNT_LO;
          else if (rx_data == PROG_CMD_END)                         w_next_state = ST_DONE;
          else                                                      w_err_set    = 1'b1;
        end
      end
      ST_CNT_LO: if (rx_valid) w_next_state = ST_CNT_HI;
      ST_CNT_HI: begin
        if (rx_valid) begin
          if (w_count == 16'd0) begin
            w_next_state = ST_IDLE;
          end else if (w_count > 16'(MAX_WORDS)) begin
            w_next_state = ST_IDLE;
            w_err_set    = 1'b1;
          end else begin
            w_next_state = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_word_ready && ({1'b0, w_idx_next} == r_count)) begin
`ifdef UART_PROG_LOADER_CHECKSUM_EN
          w_next_state = ST_CSUM;
`else
          w_next_state = ST_IDLE;
`endif
        end
      end
      ST_CSUM: begin
`ifdef UART_PROG_LOADER_CHECKSUM_EN
        if (rx_valid) begin
          w_next_state = ST_IDLE;
          w_err_set    = (rx_data != r_csum);
        end
`else
        w_next_state = ST_IDLE;
`endif
      end
      ST_DONE: w_next_state = ST_DONE;
      default: w_next_state = ST_IDLE;
    endcase
    if (w_timeout) begin
      w_next_state = ST_IDLE;
      w_err_set    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg      <= 1'b0;
      r_cnt_lo   <= '0;
      r_count    <= '0;
      r_word_idx <= '0;
      r_gap      <= '0;
      r_wen      <= 1'b0;
      r_adr      <= '0;
      r_dat      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_wen <= w_word_ready;
      if (w_err_set) r_err <= 1'b1;
      if (rx_valid || !w_busy || w_timeout) r_gap <= '0;
      else                                  r_gap <= r_gap + 1'b1;
      if (r_state == ST_IDLE && rx_valid) r_seg <= rx_data[0];
      if (r_state == ST_CNT_LO && rx_valid) r_cnt_lo <= rx_data;
      if (r_state == ST_CNT_HI && rx_valid) begin
        r_count    <= w_count;
        r_word_idx <= '0;
      end
      if (w_word_ready) begin
        r_adr      <= {r_seg, r_word_idx[SEG_BIT-1:0]};
        r_dat      <= w_word;
        r_word_idx <= w_idx_next;
      end
    end
  end

`ifdef UART_PROG_LOADER_CHECKSUM_EN
  // Running XOR over the count and payload bytes of the current record.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_csum <= '0;
    end else if (rx_valid) begin
      if (r_state == ST_IDLE) r_csum <= '0;
      else if (r_state == ST_CNT_LO || r_state == ST_CNT_HI || r_state == ST_DATA)
        r_csum <= r_csum ^ rx_data;
    end
  end
`endif

  assign upg_wen_o  = r_wen;
  assign upg_adr_o  = r_adr;
  assign upg_dat_o  = r_dat;
  assign upg_done_o = (r_state == ST_DONE);
  assign err_o      = r_err;
  assign busy_o     = w_busy;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: expected writes are queued as bytes
// are driven and popped by a monitor when the loader strobes upg_wen_o.
module tb_uart_prog_loader;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        upg_wen_o;
  logic [14:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic        upg_done_o;
  logic        err_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [46:0] sb[$];

  uart_prog_loader #(.TIMEOUT_CYCLES(TMO), .MAX_WORDS(16384)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .upg_wen_o  (upg_wen_o),
    .upg_adr_o  (upg_adr_o),
    .upg_dat_o  (upg_dat_o),
    .upg_done_o (upg_done_o),
    .err_o      (err_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (upg_wen_o === 1'b1) begin
      logic [46:0] exp_w;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL wen_unexpected adr=%h dat=%h required no write", upg_adr_o, upg_dat_o);
      end else begin
        exp_w = sb.pop_front();
        if ({upg_adr_o, upg_dat_o} !== exp_w) begin
          n_fail++;
          $display("FAIL write adr=%h dat=%h required adr=%h dat=%h",
                   upg_adr_o, upg_dat_o, exp_w[46:32], exp_w[31:0]);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic apply_reset();
    sb.delete();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_drained(input string tag);
    idle(3);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_pending_writes got %0d required 0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic send_record(input logic [7:0] cmd, input int n,
                             input logic [31:0] w0, input logic [31:0] w1);
    logic [31:0] w;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
    logic [7:0] cs;
    cs = 8'(n) ^ 8'(n >> 8);
`endif
    send(cmd);
    send(8'(n));
    send(8'(n >> 8));
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? w0 : w1;
      sb.push_back({cmd[0], 14'(i), w});
      for (int b = 0; b < 4; b++) begin
`ifdef UART_PROG_LOADER_CHECKSUM_EN
        cs = cs ^ w[8*b +: 8];
`endif
        send(w[8*b +: 8]);
      end
    end
`ifdef UART_PROG_LOADER_CHECKSUM_EN
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_before_csum got %b required 1", busy_o);
    end
    send(cs);
`endif
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_after_record got %b required 0", busy_o);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, err_o, busy_o} !== 51'd0) begin
      n_fail++;
      $display("FAIL reset_state got wen=%b adr=%h dat=%h done=%b err=%b busy=%b required all 0",
               upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, err_o, busy_o);
    end
  endtask

  task automatic test_inst_segment();
    apply_reset();
    send(8'h00); send(8'h02); send(8'h00);
    sb.push_back({1'b0, 14'd0, 32'h12345678});
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    n_checks++;
    if (upg_wen_o !== 1'b1) begin
      n_fail++;
      $display("FAIL write_latency wen=%b required 1 one cycle after 4th byte", upg_wen_o);
    end
    idle(4);
    n_checks++;
    if (upg_wen_o !== 1'b0 || upg_adr_o !== 15'h0000 || upg_dat_o !== 32'h12345678 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_between_words wen=%b adr=%h dat=%h busy=%b required 0 0000 12345678 1",
               upg_wen_o, upg_adr_o, upg_dat_o, busy_o);
    end
    sb.push_back({1'b0, 14'd1, 32'hDEADBEEF});
`ifdef UART_PROG_LOADER_CHECKSUM_EN
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    send(8'h02 ^ 8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12 ^ 8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE);
`else
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
`endif
    n_checks++;
    if (busy_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL inst_end busy=%b err=%b required 0 0", busy_o, err_o);
    end
    check_drained("inst");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    send_record(8'h01, 2, 32'hCAFEF00D, 32'h0BADC0DE);
    send_record(8'h00, 1, 32'hA5A55A5A, 32'h0);
    check_drained("b2b");
    n_checks++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_err got %b required 0", err_o);
    end
  endtask

  task automatic test_bad_cmd();
    apply_reset();
    send(8'h55);
    n_checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_cmd err=%b busy=%b required 1 0", err_o, busy_o);
    end
    send_record(8'h00, 1, 32'h11223344, 32'h0);
    check_drained("after_bad_cmd");
  endtask

  task automatic test_count_bounds();
    apply_reset();
    send(8'h00); send(8'h00); send(8'h00);
    n_checks++;
    if (busy_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL count_zero busy=%b err=%b required 0 0", busy_o, err_o);
    end
    send(8'h00); send(8'h00); send(8'h40);
    n_checks++;
    if (busy_o !== 1'b1 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL count_max busy=%b err=%b required 1 0", busy_o, err_o);
    end
    apply_reset();
    send(8'h01); send(8'h01); send(8'h40);
    n_checks++;
    if (busy_o !== 1'b0 || err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL count_over_max busy=%b err=%b required 0 1", busy_o, err_o);
    end
    check_drained("count");
  endtask

  task automatic test_timeout();
    apply_reset();
    send(8'h00); send(8'h01); send(8'h00); send(8'hAA);
    idle(TMO - 3);
    n_checks++;
    if (err_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_early err=%b busy=%b required 0 1", err_o, busy_o);
    end
    idle(5);
    n_checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_fire err=%b busy=%b required 1 0", err_o, busy_o);
    end
    send_record(8'h00, 1, 32'h44332211, 32'h0);
    check_drained("timeout");
    // Byte landing exactly on the terminal count must keep the record alive.
    apply_reset();
    send(8'h00); send(8'h01);
    idle(TMO - 1);
    send(8'h00);
    sb.push_back({1'b0, 14'd0, 32'h87654321});
    send(8'h21); send(8'h43); send(8'h65); send(8'h87);
`ifdef UART_PROG_LOADER_CHECKSUM_EN
    send(8'h01 ^ 8'h21 ^ 8'h43 ^ 8'h65 ^ 8'h87);
`endif
    n_checks++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_byte_wins err=%b required 0", err_o);
    end
    check_drained("byte_wins");
  endtask

  task automatic test_reset_mid_record();
    apply_reset();
    send(8'h00); send(8'h01); send(8'h00);
    sb.push_back({1'b0, 14'd0, 32'h0});
    send(8'hAA); send(8'hBB); send(8'hCC);
    sb.delete();
    reset = 1'b1;
    #1;
    n_checks++;
    if ({upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, err_o, busy_o} !== 51'd0) begin
      n_fail++;
      $display("FAIL reset_mid_record wen=%b adr=%h dat=%h done=%b err=%b busy=%b required all 0",
               upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, err_o, busy_o);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(8'hDD);
    n_checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_next_is_cmd err=%b busy=%b required 1 0", err_o, busy_o);
    end
    check_drained("reset_mid");
  endtask

`ifdef UART_PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    apply_reset();
    send(8'h00); send(8'h01); send(8'h00);
    sb.push_back({1'b0, 14'd0, 32'h04030201});
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h05);
    n_checks++;
    if (err_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL csum_good err=%b busy=%b required 0 0", err_o, busy_o);
    end
    send(8'h00); send(8'h01); send(8'h00);
    sb.push_back({1'b0, 14'd0, 32'h04030201});
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h06);
    n_checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL csum_bad err=%b busy=%b required 1 0", err_o, busy_o);
    end
    check_drained("csum");
  endtask
`endif

  task automatic test_done();
    apply_reset();
    send_record(8'h01, 1, 32'h01020304, 32'h0);
    send(8'hFF);
    n_checks++;
    if (upg_done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL done_set got %b required 1", upg_done_o);
    end
    send(8'h00); send(8'h01); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    idle(5);
    n_checks++;
    if (upg_done_o !== 1'b1 || busy_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL done_sticky done=%b busy=%b err=%b required 1 0 0", upg_done_o, busy_o, err_o);
    end
    check_drained("done");
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_inst_segment();
    test_back_to_back();
    test_bad_cmd();
    test_count_bounds();
    test_timeout();
    test_reset_mid_record();
`ifdef UART_PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
